// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared state encoding and size helpers for the iterative comparator
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } comp_state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Index width never drops below one bit so NDIG == 1 still has a legal idx register.
    function automatic int calc_idx_w(input int ndig);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < ndig) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/comp_iter_n_bit_if.sv
// rtl/comp_iter_n_bit_if.sv - operand/result handshake bundle for the iterative comparator
interface comp_iter_n_bit_if
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
);
    localparam int CNT_W = calc_idx_w(calc_ndig(WIDTH, DIGIT)) + 1;

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             res_valid;
    logic             res_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start_valid, a, b, signed_mode, res_ready,
        input  start_ready, res_valid, gt, eq, lt, cycles
    );

    modport slave (
        input  start_valid, a, b, signed_mode, res_ready,
        output start_ready, res_valid, gt, eq, lt, cycles
    );

endinterface

// File: rtl/comp_digit.sv
// rtl/comp_digit.sv - combinational DIGIT-bit unsigned slice comparator
module comp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

// File: rtl/comp_iter_n_bit.sv
// rtl/comp_iter_n_bit.sv - MSB-first slice-serial magnitude comparator with early exit
module comp_iter_n_bit
    import comp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    comp_iter_n_bit_if.slave    bus
);
    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int IDX_W = calc_idx_w(NDIG);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    comp_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cycles_q, cycles_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

    logic [WIDTH-1:0] flip_mask;
    logic [DIGIT-1:0] slice_a, slice_b;
    logic             sl_gt, sl_eq, sl_lt;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign flip_mask = (SIGNED_EN && bus.signed_mode) ? MSB_MASK : '0;

    assign slice_a = DIGIT'(a_q >> (DIGIT * int'(idx_q)));
    assign slice_b = DIGIT'(b_q >> (DIGIT * int'(idx_q)));

    comp_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (slice_a),
        .b  (slice_b),
        .gt (sl_gt),
        .eq (sl_eq),
        .lt (sl_lt)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.a ^ flip_mask;
                    b_d     = bus.b ^ flip_mask;
                    idx_d   = IDX_TOP;
                    cnt_d   = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                cnt_d = cnt_q + 1'b1;
                if (sl_gt || sl_lt || idx_q == '0) begin
                    gt_d     = sl_gt;
                    lt_d     = sl_lt;
                    eq_d     = sl_eq;
                    cycles_d = cnt_q + 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                    cycles_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.gt          = gt_q;
    assign bus.eq          = eq_q;
    assign bus.lt          = lt_q;
    assign bus.cycles      = cycles_q;

endmodule

// File: tb/tb_comp_iter_n_bit.sv
// tb/tb_comp_iter_n_bit.sv - directed and digit-sweep bench for comp_iter_n_bit
module tb_comp_iter_n_bit;
    import comp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    comp_iter_n_bit_if #(.WIDTH(16), .DIGIT(4)) mif ();
    comp_iter_n_bit #(.WIDTH(16), .DIGIT(4), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    localparam int NSW = 5;
    localparam int SW_DIG [NSW] = '{1, 2, 4, 8, 16};

    logic            sw_valid, sw_rready, sw_sm;
    logic [15:0]     sw_a, sw_b;
    logic [NSW-1:0]  sw_rv, sw_gt, sw_eq, sw_lt;
    logic [7:0]      sw_cyc [NSW];

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        comp_iter_n_bit_if #(.WIDTH(16), .DIGIT(SW_DIG[g])) sif ();
        comp_iter_n_bit #(.WIDTH(16), .DIGIT(SW_DIG[g]), .SIGNED_EN(1'b1)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sif)
        );
        assign sif.start_valid = sw_valid;
        assign sif.a           = sw_a;
        assign sif.b           = sw_b;
        assign sif.signed_mode = sw_sm;
        assign sif.res_ready   = sw_rready;
        assign sw_rv[g]        = sif.res_valid;
        assign sw_gt[g]        = sif.gt;
        assign sw_eq[g]        = sif.eq;
        assign sw_lt[g]        = sif.lt;
        assign sw_cyc[g]       = 8'(sif.cycles);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sr"},   32'(mif.start_ready), 1);
        check({tag, "_rv"},   32'(mif.res_valid), 0);
        check({tag, "_gel"},  32'({mif.gt, mif.eq, mif.lt}), 0);
        check({tag, "_cyc"},  32'(mif.cycles), 0);
    endtask

    task automatic start_txn(input logic [15:0] a, input logic [15:0] b, input logic s);
        mif.a           = a;
        mif.b           = b;
        mif.signed_mode = s;
        mif.start_valid = 1'b1;
        tick();
        mif.start_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output bit sr_low);
        lat    = 0;
        sr_low = 1'b1;
        while (!mif.res_valid && lat < 40) begin
            if (mif.start_ready) sr_low = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        mif.res_ready = 1'b1;
        tick();
        mif.res_ready = 1'b0;
        check_idle({tag, "_rel"});
    endtask

    task automatic do_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [2:0] exp_gel, input int exp_cyc);
        int lat;
        bit sr_low;
        start_txn(a, b, s);
        wait_result(lat, sr_low);
        check({tag, "_gel"},    32'({mif.gt, mif.eq, mif.lt}), 32'(exp_gel));
        check({tag, "_cyc"},    32'(mif.cycles), 32'(exp_cyc));
        check({tag, "_lat"},    32'(lat), 32'(exp_cyc));
        check({tag, "_srlow"},  32'(sr_low), 1);
        check({tag, "_srdone"}, 32'(mif.start_ready), 0);
        release_result(tag);
    endtask

    function automatic int exp_cycles(input logic [15:0] a, input logic [15:0] b,
                                      input logic s, input int d);
        int xa, xb, n, m;
        xa = int'(a ^ (s ? 16'h8000 : 16'h0000));
        xb = int'(b ^ (s ? 16'h8000 : 16'h0000));
        n  = 16 / d;
        m  = (1 << d) - 1;
        for (int i = n - 1; i >= 0; i--) begin
            if (((xa >> (i * d)) & m) != ((xb >> (i * d)) & m)) return n - i;
        end
        return n;
    endfunction

    initial begin
        int          lat;
        bit          sr_low;
        logic [15:0] ra, rb;
        logic [2:0]  egel;
        int          sw_lat;

        rst_n           = 1'b0;
        mif.start_valid = 1'b0;
        mif.a           = '0;
        mif.b           = '0;
        mif.signed_mode = 1'b0;
        mif.res_ready   = 1'b0;
        sw_valid        = 1'b0;
        sw_rready       = 1'b0;
        sw_sm           = 1'b0;
        sw_a            = '0;
        sw_b            = '0;
        repeat (3) tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        do_txn("eq1234",   16'h1234, 16'h1234, 1'b0, 3'b010, 4);
        do_txn("u8000",    16'h8000, 16'h7FFF, 1'b0, 3'b100, 1);
        do_txn("s8000",    16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);
        do_txn("lt12a4",   16'h12A4, 16'h12B4, 1'b0, 3'b001, 3);
        do_txn("s_neg",    16'hFFFE, 16'hFFFF, 1'b1, 3'b001, 4);

        // Backpressure: result held while start_valid/a/b wiggle underneath.
        start_txn(16'hFFFF, 16'h0000, 1'b0);
        wait_result(lat, sr_low);
        check("hold_lat", 32'(lat), 1);
        for (int i = 0; i < 5; i++) begin
            mif.start_valid = ~mif.start_valid;
            mif.a           = 16'($urandom);
            mif.b           = 16'($urandom);
            tick();
            check("hold_gel", 32'({mif.gt, mif.eq, mif.lt}), 32'(3'b100));
            check("hold_cyc", 32'(mif.cycles), 1);
            check("hold_rv",  32'(mif.res_valid), 1);
            check("hold_sr",  32'(mif.start_ready), 0);
        end
        mif.start_valid = 1'b0;
        release_result("hold");

        // Asynchronous reset in the middle of a 4-slice compare.
        start_txn(16'h0001, 16'h0002, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        do_txn("postrst", 16'h0001, 16'h0002, 1'b0, 3'b001, 4);

        // Digit sweep across all instances in lockstep.
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            case (i % 3)
                0:       rb = 16'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (16'h1 << $urandom_range(15, 0));
            endcase
            for (int s = 0; s < 2; s++) begin
                sw_a     = ra;
                sw_b     = rb;
                sw_sm    = s[0];
                sw_valid = 1'b1;
                tick();
                sw_valid = 1'b0;
                sw_lat   = 0;
                while (sw_rv != {NSW{1'b1}} && sw_lat < 40) begin
                    tick();
                    sw_lat++;
                end
                check("sw_timeout", 32'(sw_lat >= 40), 0);
                if (s == 1)
                    egel = {$signed(ra) > $signed(rb), ra == rb, $signed(ra) < $signed(rb)};
                else
                    egel = {ra > rb, ra == rb, ra < rb};
                for (int g = 0; g < NSW; g++) begin
                    check($sformatf("sw_d%0d_gel_%04h_%04h_s%0d", SW_DIG[g], ra, rb, s),
                          32'({sw_gt[g], sw_eq[g], sw_lt[g]}), 32'(egel));
                    check($sformatf("sw_d%0d_cyc_%04h_%04h_s%0d", SW_DIG[g], ra, rb, s),
                          32'(sw_cyc[g]), 32'(exp_cycles(ra, rb, s[0], SW_DIG[g])));
                end
                sw_rready = 1'b1;
                tick();
                sw_rready = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
